// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
//   XLEN      : operand/result width, also the number of iterations per operation
//   CNT_W     : width of the iteration counter (counts 0 .. XLEN-1)
//   F3_*      : RV32M funct3 operation encodings
//   state_t   : control FSM state encoding
package muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN);

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// Datapath of the multiply/divide unit: a 2*XLEN accumulator {hi, lo} plus
// the second operand register, advanced by one shift-add (multiply) or one
// restoring-subtract (divide) step per enabled cycle.
//   clock, reset : system clock, synchronous active-high reset
//   load         : load lo <= load_lo, hi <= 0, operand <= load_operand
//   step         : perform one iteration
//   is_div       : selects restoring divide (1) or shift-add multiply (0)
//   load_lo      : multiplier magnitude / dividend magnitude
//   load_operand : multiplicand magnitude / divisor magnitude
//   next_hi/lo   : accumulator value after the step taken this cycle
//                  (multiply: product {hi,lo}; divide: hi=remainder, lo=quotient)
module muldiv_iter_core
    import muldiv_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic            step,
    input  logic            is_div,
    input  logic [XLEN-1:0] load_lo,
    input  logic [XLEN-1:0] load_operand,
    output logic [XLEN-1:0] next_hi,
    output logic [XLEN-1:0] next_lo
);

    logic [XLEN-1:0] acc_hi_reg, acc_lo_reg, operand_reg;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   partial;
    logic [XLEN:0]   diff;

    always_comb begin
        // Multiply: add the multiplicand when the current multiplier bit is
        // set, then shift the whole {carry, hi, lo} right by one.
        sum     = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, operand_reg} : '0);
        // Divide: shift the next dividend bit into the partial remainder and
        // trial-subtract; bit XLEN of diff set means the subtraction went
        // negative, since the partial remainder is always below 2*divisor.
        partial = {acc_hi_reg, acc_lo_reg[XLEN-1]};
        diff    = partial - {1'b0, operand_reg};

        next_hi = acc_hi_reg;
        next_lo = acc_lo_reg;
        if (step) begin
            if (!is_div) begin
                next_hi = sum[XLEN:1];
                next_lo = {sum[0], acc_lo_reg[XLEN-1:1]};
            end else if (!diff[XLEN]) begin
                next_hi = diff[XLEN-1:0];
                next_lo = {acc_lo_reg[XLEN-2:0], 1'b1};
            end else begin
                next_hi = partial[XLEN-1:0];
                next_lo = {acc_lo_reg[XLEN-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_hi_reg  <= '0;
            acc_lo_reg  <= '0;
            operand_reg <= '0;
        end else if (load) begin
            acc_hi_reg  <= '0;
            acc_lo_reg  <= load_lo;
            operand_reg <= load_operand;
        end else begin
            acc_hi_reg  <= next_hi;
            acc_lo_reg  <= next_lo;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit between the register file read ports
// and its write port. Fixed latency: start accepted at edge E gives a one-cycle
// wEn pulse between edges E+XLEN and E+XLEN+1; busy covers E .. E+XLEN+1.
//   clock, reset       : system clock, synchronous active-high reset
//   start              : request, only looked at while idle
//   funct3             : RV32M operation select
//   rs1_data, rs2_data : operands A and B
//   rd                 : destination register index
//   busy               : operation in flight (including the writeback cycle)
//   wEn                : one-cycle register file write enable (never for rd==0)
//   write_reg          : destination index, held between operations
//   write_data         : result, held between operations
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd,
    output logic            busy,
    output logic            wEn,
    output logic [4:0]      write_reg,
    output logic [XLEN-1:0] write_data
);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [2:0]        funct3_reg;
    logic [4:0]        rd_reg;
    logic              neg_prod_reg;   // product / quotient needs negation
    logic              neg_rem_reg;    // remainder follows dividend sign
    logic              div0_reg;
    logic              wb_en_reg;
    logic [4:0]        wb_idx_reg;
    logic [XLEN-1:0]   wb_data_reg;

    logic              load, step, last_iter;
    logic              signed_a, signed_b, sign_a, sign_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN-1:0]   core_hi, core_lo;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quot, rem, result;

    // Operand sign handling: rs1 is signed for MULH/MULHSU/DIV/REM,
    // rs2 only for MULH/DIV/REM. The core always works on magnitudes.
    always_comb begin
        signed_a = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                   (funct3 == F3_DIV)  || (funct3 == F3_REM);
        signed_b = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
        sign_a   = signed_a && rs1_data[XLEN-1];
        sign_b   = signed_b && rs2_data[XLEN-1];
        mag_a    = sign_a ? -rs1_data : rs1_data;
        mag_b    = sign_b ? -rs2_data : rs2_data;
    end

    muldiv_iter_core u_core (
        .clock        (clock),
        .reset        (reset),
        .load         (load),
        .step         (step),
        .is_div       (funct3_reg[2]),
        .load_lo      (mag_a),
        .load_operand (mag_b),
        .next_hi      (core_hi),
        .next_lo      (core_lo)
    );

    assign last_iter = (count_reg == CNT_W'(XLEN - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        load       = 1'b0;
        step       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_CALC;
                    count_next = '0;
                end
            end
            ST_CALC: begin
                step = 1'b1;
                if (last_iter) begin
                    state_next = ST_DONE;
                    count_next = '0;
                end else begin
                    count_next = count_reg + CNT_W'(1);
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            funct3_reg   <= '0;
            rd_reg       <= '0;
            neg_prod_reg <= 1'b0;
            neg_rem_reg  <= 1'b0;
            div0_reg     <= 1'b0;
        end else if (load) begin
            funct3_reg   <= funct3;
            rd_reg       <= rd;
            neg_prod_reg <= sign_a ^ sign_b;
            neg_rem_reg  <= sign_a;
            div0_reg     <= (rs2_data == '0);
        end
    end

    // Sign fix-up applied to the core's final step. Divide by zero yields
    // all-ones quotient explicitly; its remainder is the dividend magnitude
    // re-signed, i.e. the raw dividend. Signed overflow falls out naturally.
    always_comb begin
        prod     = {core_hi, core_lo};
        prod_fix = neg_prod_reg ? -prod : prod;
        quot     = div0_reg ? '1 : (neg_prod_reg ? -core_lo : core_lo);
        rem      = neg_rem_reg ? -core_hi : core_hi;
        case (funct3_reg)
            F3_MUL:                       result = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: result = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              result = quot;
            default:                      result = rem;
        endcase
    end

    // Writeback registers load on the last CALC edge so they are valid for
    // the whole DONE cycle and hold afterwards.
    always_ff @(posedge clock) begin
        if (reset) begin
            wb_en_reg   <= 1'b0;
            wb_idx_reg  <= '0;
            wb_data_reg <= '0;
        end else begin
            wb_en_reg <= 1'b0;
            if (state_reg == ST_CALC && last_iter) begin
                wb_en_reg   <= (rd_reg != 5'd0);
                wb_idx_reg  <= rd_reg;
                wb_data_reg <= result;
            end
        end
    end

    assign busy       = (state_reg != ST_IDLE);
    assign wEn        = wb_en_reg;
    assign write_reg  = wb_idx_reg;
    assign write_data = wb_data_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, hand-written
// sequences for rd==0 / ignored start / reset abort, and random operations
// checked against a plain-arithmetic reference model.
module tb_muldiv_unit;

    localparam int XLEN = 32;

    logic            clock = 1'b0;
    logic            reset;
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic [4:0]      rd;
    logic            busy, wEn;
    logic [4:0]      write_reg;
    logic [XLEN-1:0] write_data;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_unit dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .funct3     (funct3),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .rd         (rd),
        .busy       (busy),
        .wEn        (wEn),
        .write_reg  (write_reg),
        .write_data (write_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model straight from the RV32M rules.
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        int     ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Called at a negedge. Issues one operation, observes XLEN+2 cycles and
    // returns at the negedge where busy must already be low, so the next call
    // starts right in the first idle cycle. repulse_at >= 1 raises start again
    // (with junk operands) at that observation index.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd_i, input logic [31:0] exp, input int repulse_at);
        int          wen_cnt = 0;
        int          wen_at = -1;
        int          busy_cnt = 0;
        logic        busy_after = 1'b1;
        logic [31:0] data_seen = '0;
        logic [4:0]  reg_seen = '0;
        funct3 = f3; rs1_data = a; rs2_data = b; rd = rd_i; start = 1'b1;
        @(posedge clock);
        for (int i = 0; i <= XLEN + 1; i++) begin
            @(negedge clock);
            if (i == 0) start = 1'b0;
            if (i == repulse_at) begin
                start = 1'b1;
                funct3 = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom;
                rd = 5'($urandom_range(1, 31));
            end else if (i == repulse_at + 1) begin
                start = 1'b0;
            end
            if (i <= XLEN) busy_cnt += int'(busy);
            else busy_after = busy;
            if (wEn) begin
                wen_cnt++;
                wen_at = i;
                data_seen = write_data;
                reg_seen = write_reg;
            end
        end
        $display("op f3=%0d rs1=0x%08h rs2=0x%08h rd=%0d -> wEn_count=%0d data=0x%08h (exp 0x%08h)",
                 f3, a, b, rd_i, wen_cnt, data_seen, exp);
        check("busy_cycles", 64'(busy_cnt), 64'(XLEN + 1));
        check("busy_after_done", 64'(busy_after), 64'd0);
        check("wen_count", 64'(wen_cnt), (rd_i != 0) ? 64'd1 : 64'd0);
        if (rd_i != 0) begin
            check("wen_latency", 64'(wen_at), 64'(XLEN));
            check("write_data", 64'(data_seen), 64'(exp));
            check("write_reg", 64'(reg_seen), 64'(rd_i));
        end
    endtask

    initial begin
        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0000};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF};
        vecs[4]  = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'h0000_0001};
        vecs[5]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFD};
        vecs[6]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFF};
        vecs[7]  = '{3'd5, 32'd100,       32'd7,         5'd8,  32'd14};
        vecs[8]  = '{3'd7, 32'd100,       32'd7,         5'd10, 32'd2};
        vecs[9]  = '{3'd4, 32'd100,       32'd0,         5'd11, 32'hFFFF_FFFF};
        vecs[10] = '{3'd6, 32'd100,       32'd0,         5'd12, 32'd100};
        vecs[11] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000};
        vecs[12] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0};
        vecs[13] = '{3'd5, 32'd5,         32'd0,         5'd15, 32'hFFFF_FFFF};
        vecs[14] = '{3'd7, 32'd5,         32'd0,         5'd16, 32'd5};
        vecs[15] = '{3'd4, 32'hFFFF_FF9C, 32'd0,         5'd17, 32'hFFFF_FFFF};
        vecs[16] = '{3'd6, 32'hFFFF_FF9C, 32'd0,         5'd18, 32'hFFFF_FF9C};

        reset = 1'b1; start = 1'b0; funct3 = '0; rs1_data = '0; rs2_data = '0; rd = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_wen", 64'(wEn), 64'd0);
        check("reset_write_reg", 64'(write_reg), 64'd0);
        check("reset_write_data", 64'(write_data), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // Directed table, issued back to back.
        for (int v = 0; v < 17; v++)
            run_op(vecs[v].f3, vecs[v].a, vecs[v].b, vecs[v].rd, vecs[v].exp, -1);

        // rd==0: full latency, no write; start re-pulsed mid-CALC is ignored.
        run_op(3'd0, 32'd3, 32'd4, 5'd0, 32'd12, 5);
        // Start during DONE is ignored too; only the original op writes back.
        run_op(3'd0, 32'd9, 32'd9, 5'd20, 32'd81, XLEN);

        // Reset at CALC iteration 10 aborts with no writeback.
        begin
            int late_wen = 0;
            funct3 = 3'd0; rs1_data = 32'd1000; rs2_data = 32'd1000; rd = 5'd21; start = 1'b1;
            @(posedge clock);
            for (int i = 0; i <= 10; i++) begin
                @(negedge clock);
                if (i == 0) start = 1'b0;
            end
            reset = 1'b1;
            @(posedge clock);
            @(negedge clock);
            $display("reset at CALC iteration 10 -> busy=%0d wEn=%0d", busy, wEn);
            check("abort_busy", 64'(busy), 64'd0);
            check("abort_wen", 64'(wEn), 64'd0);
            check("abort_write_data", 64'(write_data), 64'd0);
            check("abort_write_reg", 64'(write_reg), 64'd0);
            reset = 1'b0;
            for (int i = 0; i < XLEN + 4; i++) begin
                @(negedge clock);
                if (wEn || busy) late_wen++;
            end
            check("abort_no_late_activity", 64'(late_wen), 64'd0);
        end
        run_op(3'd0, 32'd6, 32'd7, 5'd9, 32'd42, -1);

        // Random operations against the reference model.
        for (int r = 0; r < 60; r++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            logic [4:0]  d;
            f3 = 3'($urandom);
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'hFFFF_FFFF;
                default: ;
            endcase
            d = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            run_op(f3, a, b, d, ref_model(f3, a, b), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
